// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory bus bundle for mem_port_arbiter
//
// Purpose: groups the fetch port, data port and memory macro signals that
// mem_port_arbiter arbitrates between.
// Ports (signals):
//   if_req/if_addr            fetch request in, if_gnt/if_done/if_rdata out
//   d_req/d_we/d_addr/d_wdata data request in, d_gnt/d_done/d_rdata out
//   mem_en/mem_we/mem_addr/mem_wdata to memory, mem_rdata from memory
//   busy                      arbiter not idle
// Modports: slave = arbiter side, master = requesters plus memory model.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_done;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_done;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_done, if_rdata, d_gnt, d_done, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_done, if_rdata, d_gnt, d_done, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter for the single-port unified memory
//
// Purpose: shares one memory port between instruction fetch (IF) and data
// access (D). IDLE -> ACCESS (MEM_LAT cycles) -> DONE -> IDLE; every output
// is registered.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high
//   bus    mem_port_arbiter_if.slave (requester handshakes, memory bus, busy)
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus
);
  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic OWN_D  = 1'b0;
  localparam logic OWN_IF = 1'b1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic              if_gnt_q, if_gnt_d, d_gnt_q, d_gnt_d;
  logic              if_done_q, if_done_d, d_done_q, d_done_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              busy_q, busy_d;
  logic              pick_if;

  // On a conflict the requester that did not win last time takes the port.
  assign pick_if = bus.if_req && (!bus.d_req || (last_q == OWN_D));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      owner_q     <= OWN_D;
      last_q      <= OWN_IF;
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      if_gnt_q    <= if_gnt_d;
      d_gnt_q     <= d_gnt_d;
      if_done_q   <= if_done_d;
      d_done_q    <= d_done_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.if_req || bus.d_req) state_d = ACCESS;
      ACCESS:  if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    last_d      = last_q;
    if_gnt_d    = 1'b0;
    d_gnt_d     = 1'b0;
    if_done_d   = 1'b0;
    d_done_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    busy_d      = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        if (bus.if_req || bus.d_req) begin
          owner_d     = pick_if;
          last_d      = pick_if;
          if_gnt_d    = pick_if;
          d_gnt_d     = !pick_if;
          mem_en_d    = 1'b1;
          mem_we_d    = pick_if ? 1'b0 : bus.d_we;
          mem_addr_d  = pick_if ? bus.if_addr : bus.d_addr;
          mem_wdata_d = pick_if ? '0 : bus.d_wdata;
          cnt_d       = CNT_W'(MEM_LAT - 1);
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          if (owner_q == OWN_IF) begin
            if_rdata_d = bus.mem_rdata;
            if_done_d  = 1'b1;
          end else begin
            // A store keeps the previous load data.
            if (!mem_we_q) d_rdata_d = bus.mem_rdata;
            d_done_d = 1'b1;
          end
          mem_en_d    = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  assign bus.if_gnt    = if_gnt_q;
  assign bus.d_gnt     = d_gnt_q;
  assign bus.if_done   = if_done_q;
  assign bus.d_done    = d_done_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [31:0] tb_mem [64];
  logic exp_if [3];

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  always #5 clk = ~clk;

  assign bus0.mem_rdata = bus0.mem_en ? tb_mem[bus0.mem_addr[7:2]] : 32'h0;
  assign bus1.mem_rdata = bus1.mem_en ? 32'h0BADF00D : 32'h0;

  always @(posedge clk) begin
    if (bus0.mem_en && bus0.mem_we) tb_mem[bus0.mem_addr[7:2]] <= bus0.mem_wdata;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    reset = 1'b0;
    checks = 0;
    errors = 0;
    for (int i = 0; i < 64; i++) tb_mem[i] = 32'h0;
    tb_mem[4]  = 32'hDEADBEEF;
    tb_mem[17] = 32'hCAFE0044;
    exp_if[0] = 1'b0; exp_if[1] = 1'b1; exp_if[2] = 1'b0;
    bus0.if_req = 0; bus0.if_addr = 0; bus0.d_req = 0; bus0.d_we = 0;
    bus0.d_addr = 0; bus0.d_wdata = 0;
    bus1.if_req = 0; bus1.if_addr = 0; bus1.d_req = 0; bus1.d_we = 0;
    bus1.d_addr = 0; bus1.d_wdata = 0;
    #2 reset = 1'b1;
    tick; tick;
    check("rst_mem_en", {31'b0, bus0.mem_en}, 0);
    check("rst_busy", {31'b0, bus0.busy}, 0);
    check("rst_gnt", {30'b0, bus0.if_gnt, bus0.d_gnt}, 0);
    check("rst_if_rdata", bus0.if_rdata, 0);
    check("rst_d_rdata", bus0.d_rdata, 0);
    check("rst_mem_addr", bus0.mem_addr, 0);
    reset = 1'b0;

    // 1: single fetch
    tick;
    bus0.if_req = 1; bus0.if_addr = 32'h10;
    check("t1_idle_busy", {31'b0, bus0.busy}, 0);
    tick;
    check("t1_gnt", {30'b0, bus0.if_gnt, bus0.d_gnt}, 2'b10);
    check("t1_mem_en1", {31'b0, bus0.mem_en}, 1);
    check("t1_mem_addr", bus0.mem_addr, 32'h10);
    check("t1_mem_we", {31'b0, bus0.mem_we}, 0);
    check("t1_busy", {31'b0, bus0.busy}, 1);
    tick;
    check("t1_gnt_pulse", {31'b0, bus0.if_gnt}, 0);
    check("t1_mem_en2", {31'b0, bus0.mem_en}, 1);
    check("t1_no_done_yet", {31'b0, bus0.if_done}, 0);
    tick;
    check("t1_done", {30'b0, bus0.if_done, bus0.d_done}, 2'b10);
    check("t1_rdata", bus0.if_rdata, 32'hDEADBEEF);
    check("t1_mem_en_off", {31'b0, bus0.mem_en}, 0);
    bus0.if_req = 0;
    tick;
    check("t1_done_pulse", {31'b0, bus0.if_done}, 0);
    check("t1_idle", {31'b0, bus0.busy}, 0);

    // 2: store then load back
    bus0.d_req = 1; bus0.d_we = 1; bus0.d_addr = 32'h40; bus0.d_wdata = 32'h1234;
    tick;
    check("t2_gnt", {30'b0, bus0.if_gnt, bus0.d_gnt}, 2'b01);
    check("t2_we1", {31'b0, bus0.mem_we}, 1);
    check("t2_wdata1", bus0.mem_wdata, 32'h1234);
    tick;
    check("t2_we2", {31'b0, bus0.mem_we}, 1);
    check("t2_wdata2", bus0.mem_wdata, 32'h1234);
    tick;
    check("t2_done", {30'b0, bus0.if_done, bus0.d_done}, 2'b01);
    check("t2_rdata_unch", bus0.d_rdata, 0);
    check("t2_mem_we_off", {31'b0, bus0.mem_we}, 0);
    check("t2_written", tb_mem[16], 32'h1234);
    bus0.d_req = 0; bus0.d_we = 0; bus0.d_wdata = 0;
    tick;
    bus0.d_req = 1;
    tick;
    check("t2_ld_gnt", {31'b0, bus0.d_gnt}, 1);
    check("t2_ld_we", {31'b0, bus0.mem_we}, 0);
    tick; tick;
    check("t2_ld_done", {31'b0, bus0.d_done}, 1);
    check("t2_ld_rdata", bus0.d_rdata, 32'h1234);
    bus0.d_req = 0;
    tick;

    // 4: reset during the 2nd ACCESS cycle of a fetch
    bus0.if_req = 1; bus0.if_addr = 32'h10;
    tick;
    check("t4_gnt", {31'b0, bus0.if_gnt}, 1);
    tick;
    reset = 1'b1;
    bus0.if_req = 0;
    #1;
    check("t4_rst_mem_en", {31'b0, bus0.mem_en}, 0);
    check("t4_rst_busy", {31'b0, bus0.busy}, 0);
    check("t4_rst_if_rdata", bus0.if_rdata, 0);
    check("t4_rst_d_rdata", bus0.d_rdata, 0);
    tick;
    check("t4_no_done", {30'b0, bus0.if_done, bus0.d_done}, 0);
    reset = 1'b0;
    bus0.if_req = 1;
    tick;
    check("t4_re_gnt", {31'b0, bus0.if_gnt}, 1);
    tick; tick;
    check("t4_re_done", {31'b0, bus0.if_done}, 1);
    check("t4_re_rdata", bus0.if_rdata, 32'hDEADBEEF);
    bus0.if_req = 0;
    tick;

    // 3: both requesters held high for three transactions
    bus0.if_req = 1; bus0.if_addr = 32'h10;
    bus0.d_req = 1; bus0.d_we = 0; bus0.d_addr = 32'h44;
    for (int k = 0; k < 3; k++) begin
      tick;
      check($sformatf("t3_gnt%0d", k), {30'b0, bus0.if_gnt, bus0.d_gnt},
            exp_if[k] ? 32'd2 : 32'd1);
      tick; tick;
      check($sformatf("t3_done%0d", k), {30'b0, bus0.if_done, bus0.d_done},
            exp_if[k] ? 32'd2 : 32'd1);
      if (exp_if[k]) check($sformatf("t3_if_rdata%0d", k), bus0.if_rdata, 32'hDEADBEEF);
      else check($sformatf("t3_d_rdata%0d", k), bus0.d_rdata, 32'hCAFE0044);
      if (k == 2) begin
        bus0.if_req = 0; bus0.d_req = 0;
      end
      tick;
      check($sformatf("t3_idle%0d", k), {29'b0, bus0.busy, bus0.if_gnt, bus0.d_gnt}, 0);
    end

    // 5: d_req dropped after grant
    bus0.d_req = 1; bus0.d_addr = 32'h40;
    tick;
    check("t5_gnt", {31'b0, bus0.d_gnt}, 1);
    tick;
    bus0.d_req = 0;
    check("t5_mid", {31'b0, bus0.d_done}, 0);
    tick;
    check("t5_done", {31'b0, bus0.d_done}, 1);
    check("t5_rdata", bus0.d_rdata, 32'h1234);
    tick;
    check("t5_idle", {31'b0, bus0.busy}, 0);

    // 6: MEM_LAT = 1 instance, single fetch
    bus1.if_req = 1; bus1.if_addr = 32'h20;
    check("t6_idle_busy", {31'b0, bus1.busy}, 0);
    tick;
    check("t6_gnt", {31'b0, bus1.if_gnt}, 1);
    check("t6_busy1", {31'b0, bus1.busy}, 1);
    check("t6_mem_en", {31'b0, bus1.mem_en}, 1);
    tick;
    check("t6_done", {31'b0, bus1.if_done}, 1);
    check("t6_rdata", bus1.if_rdata, 32'h0BADF00D);
    check("t6_busy2", {31'b0, bus1.busy}, 1);
    bus1.if_req = 0;
    tick;
    check("t6_busy_off", {31'b0, bus1.busy}, 0);
    check("t6_done_pulse", {31'b0, bus1.if_done}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
